inst_queue_decoder: RTL and testbench
=====================================

// Module: inst_queue_decoder
// PURPOSE
// - Instruction queue plus registered RV32I decoder between the fetch unit and the issue/dispatch stage.
// - Buffers up to DEPTH fetched {pc, inst} pairs in a circular FIFO and decodes the head entry.
// - Presents the decoded op in an output register with a valid/ready handshake.
// - Adds full-decode defaults, illegal-instruction flagging, x0-destination suppression and pipeline flush.
// PARAMETERS
// - DEPTH   8   FIFO entries; power of two, >= 2
// - PTR_W   3   log2(DEPTH); count is PTR_W+1 bits
// PORTS
// - clk_in         in   1   clock
// - rst_in         in   1   asynchronous reset, active-high
// - rdy_in         in   1   global enable; low = all state frozen (flush ignored)
// - flush_in       in   1   discard FIFO and output register (mispredict/exception)
// - fetch_valid    in   1   fetch offers {fetch_pc, fetch_inst}
// - fetch_inst     in   32  raw instruction word
// - fetch_pc       in   32  instruction address
// - fetch_ready    out  1   FIFO not full
// - issue_ready    in   1   consumer accepts output register
// - issue_valid    out  1   output register holds a decoded op
// - issue_pc       out  32  pc of decoded op
// - issue_op       out  6   op code, operaType.v encoding
// - issue_type     out  3   op class, operaType.v encoding (IType, ILoadType, SType, BType, UType, JType, RType)
// - issue_rs1/rs2/rd  out  6  register indices; unused field = `NULL
// - issue_imm      out  32  sign/zero-extended immediate (I/S/B/U/J formats)
// - issue_illegal  out  1   unrecognised opcode/funct3/funct7 combination
// - count          out  PTR_W+1  FIFO occupancy (excludes output register)
// BEHAVIOUR
// - Reset: pointers=0; count=0; issue_valid=0; fetch_ready=1.
// - Reset: issue_pc/imm=0; issue_op/type=0; rs1/rs2/rd=`NULL; issue_illegal=0.
// - Push: fetch_valid & fetch_ready & rdy_in -> write at wr_ptr; wr_ptr wraps at DEPTH.
// - fetch_ready = (count != DEPTH).
// - A pop in the same cycle does NOT enable a push when full.
// - Load: output register loads decode(head) when count!=0 & (!issue_valid | issue_ready).
//   - Load pops the head entry.
//   - Consume without load -> issue_valid=0 next cycle.
// - Latency: push at edge N -> issue_valid at edge N+1 when output stage is free.
// - Throughput: 1 op/cycle when issue_ready is held high.
// - Simultaneous push+pop when not full: count unchanged; both pointers advance.
// - Empty FIFO with issue_ready=1: issue_valid deasserts; no pop.
// - Flush (rdy_in=1): next edge -> pointers=0, count=0, issue_valid=0.
//   - Flush overrides same-cycle push, pop and load.
// - Async reset mid-transfer: all state cleared immediately; in-flight entries discarded.
// - Decode:
//   - Fields: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], zero-extended to 6 bits.
//   - Fields not used by the format -> `NULL (rs2 for I/Load/U/J; rd for S/B; rs1 for U/J).
//   - rd==x0 -> `NULL for every format.
//   - SLLI/SRLI/SRAI imm = zero-extended shamt inst[24:20].
//   - R-type imm=0.
// - Illegal: no opcode/funct match.
//   - issue_illegal=1, op=0, type=0, imm=0, rs1/rs2/rd=`NULL.
//   - Entry is still issued (consumer traps).
//   - Outputs never retain stale values.
// CONFIGURATION
// - DECODE_RV32M_EN defined: opcode 0110011 with funct7 0000001 decodes to RType.
//   - funct3 000..111 -> MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
// - DECODE_RV32M_EN undefined: these encodings set issue_illegal=1.
// TESTING
// - ADDI: push 0x00500093, issue_ready=1.
//   -> next cycle issue_valid=1, op=ADDI, type=IType, rs1=0, rd=1, rs2=`NULL, imm=5.
// - BEQ: push 0xFE208EE3 -> op=BEQ, type=BType, rs1=1, rs2=2, rd=`NULL, imm=0xFFFFFFFC.
// - Full: issue_ready=0, push 9 ops.
//   -> 1st loads output register; after 9th, count=8 and fetch_ready=0; 10th push is ignored.
//   -> issue_ready=1 then drains all 9 in order on consecutive cycles.
// - Flush: 5 entries queued, flush_in=1 with fetch_valid=1.
//   -> next cycle count=0, issue_valid=0; pushed word is lost.
// - Illegal / x0: push 0xFFFFFFFF -> issue_illegal=1, op=0, regs `NULL.
//   -> push 0x00000013 (nop) -> op=ADDI, rd=`NULL.
// - RV32M: push 0x022081B3.
//   -> with DECODE_RV32M_EN: op=MUL, rs1=1, rs2=2, rd=3.
//   -> without it: issue_illegal=1.

Source files
------------

// File: rtl/inst_queue_decoder.sv
// inst_queue_decoder: circular instruction FIFO feeding a registered RV32I
// decoder with a valid/ready output stage, illegal-instruction flagging,
// x0-destination suppression and pipeline flush.
// Optional feature macro: DECODE_RV32M_EN. When it is defined, the RV32M
// multiply/divide encodings decode as RType ops. When it is not defined,
// those encodings are flagged as illegal.

`ifndef NULL
`define NULL 6'd32
`endif

module inst_queue_decoder #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              fetch_valid,
    input  logic [31:0]       fetch_inst,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_ready,
    input  logic              issue_ready,
    output logic              issue_valid,
    output logic [31:0]       issue_pc,
    output logic [5:0]        issue_op,
    output logic [2:0]        issue_type,
    output logic [5:0]        issue_rs1,
    output logic [5:0]        issue_rs2,
    output logic [5:0]        issue_rd,
    output logic [31:0]       issue_imm,
    output logic              issue_illegal,
    output logic [PTR_W:0]    count
);

    // Op codes
    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LH    = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd13;
    localparam logic [5:0] OP_LBU   = 6'd14;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SH    = 6'd17;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SLTI  = 6'd20;
    localparam logic [5:0] OP_SLTIU = 6'd21;
    localparam logic [5:0] OP_XORI  = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRLI  = 6'd26;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLL   = 6'd30;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;
    localparam logic [5:0] OP_XOR   = 6'd33;
    localparam logic [5:0] OP_SRL   = 6'd34;
    localparam logic [5:0] OP_SRA   = 6'd35;
    localparam logic [5:0] OP_OR    = 6'd36;
    localparam logic [5:0] OP_AND   = 6'd37;
`ifdef DECODE_RV32M_EN
    localparam logic [5:0] OP_MUL    = 6'd38;
    localparam logic [5:0] OP_MULH   = 6'd39;
    localparam logic [5:0] OP_MULHSU = 6'd40;
    localparam logic [5:0] OP_MULHU  = 6'd41;
    localparam logic [5:0] OP_DIV    = 6'd42;
    localparam logic [5:0] OP_DIVU   = 6'd43;
    localparam logic [5:0] OP_REM    = 6'd44;
    localparam logic [5:0] OP_REMU   = 6'd45;
`endif

    // Op classes (0 is reserved for illegal/none)
    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_L    = 3'd2;
    localparam logic [2:0] T_S    = 3'd3;
    localparam logic [2:0] T_B    = 3'd4;
    localparam logic [2:0] T_U    = 3'd5;
    localparam logic [2:0] T_J    = 3'd6;
    localparam logic [2:0] T_R    = 3'd7;

    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [5:0]  op;
        logic [2:0]  typ;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    // Full RV32I(+M) decode of one instruction word; illegal words yield all-default fields.
    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        f3        = inst[14:12];
        f7        = inst[31:25];
        bad       = 1'b0;
        d.op      = OP_NOP;
        d.typ     = T_NONE;
        d.rs1     = `NULL;
        d.rs2     = `NULL;
        d.rd      = `NULL;
        d.imm     = 32'd0;
        d.illegal = 1'b0;
        case (inst[6:0])
            7'b0110111: begin d.op = OP_LUI;   d.typ = T_U; end
            7'b0010111: begin d.op = OP_AUIPC; d.typ = T_U; end
            7'b1101111: begin d.op = OP_JAL;   d.typ = T_J; end
            7'b1100111: begin d.op = OP_JALR;  d.typ = T_I; bad = (f3 != 3'b000); end
            7'b1100011: begin
                d.typ = T_B;
                case (f3)
                    3'b000:  d.op = OP_BEQ;
                    3'b001:  d.op = OP_BNE;
                    3'b100:  d.op = OP_BLT;
                    3'b101:  d.op = OP_BGE;
                    3'b110:  d.op = OP_BLTU;
                    3'b111:  d.op = OP_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            7'b0000011: begin
                d.typ = T_L;
                case (f3)
                    3'b000:  d.op = OP_LB;
                    3'b001:  d.op = OP_LH;
                    3'b010:  d.op = OP_LW;
                    3'b100:  d.op = OP_LBU;
                    3'b101:  d.op = OP_LHU;
                    default: bad = 1'b1;
                endcase
            end
            7'b0100011: begin
                d.typ = T_S;
                case (f3)
                    3'b000:  d.op = OP_SB;
                    3'b001:  d.op = OP_SH;
                    3'b010:  d.op = OP_SW;
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                d.typ = T_I;
                case (f3)
                    3'b000:  d.op = OP_ADDI;
                    3'b010:  d.op = OP_SLTI;
                    3'b011:  d.op = OP_SLTIU;
                    3'b100:  d.op = OP_XORI;
                    3'b110:  d.op = OP_ORI;
                    3'b111:  d.op = OP_ANDI;
                    3'b001:  begin d.op = OP_SLLI; bad = (f7 != 7'b0000000); end
                    3'b101: begin
                        if (f7 == 7'b0000000) begin
                            d.op = OP_SRLI;
                        end else if (f7 == 7'b0100000) begin
                            d.op = OP_SRAI;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: bad = 1'b1;
                endcase
            end
            7'b0110011: begin
                d.typ = T_R;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d.op = OP_ADD;
                        3'b001:  d.op = OP_SLL;
                        3'b010:  d.op = OP_SLT;
                        3'b011:  d.op = OP_SLTU;
                        3'b100:  d.op = OP_XOR;
                        3'b101:  d.op = OP_SRL;
                        3'b110:  d.op = OP_OR;
                        3'b111:  d.op = OP_AND;
                        default: bad = 1'b1;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    case (f3)
                        3'b000:  d.op = OP_SUB;
                        3'b101:  d.op = OP_SRA;
                        default: bad = 1'b1;
                    endcase
                end else if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
                    case (f3)
                        3'b000:  d.op = OP_MUL;
                        3'b001:  d.op = OP_MULH;
                        3'b010:  d.op = OP_MULHSU;
                        3'b011:  d.op = OP_MULHU;
                        3'b100:  d.op = OP_DIV;
                        3'b101:  d.op = OP_DIVU;
                        3'b110:  d.op = OP_REM;
                        3'b111:  d.op = OP_REMU;
                        default: bad = 1'b1;
                    endcase
`else
                    bad = 1'b1;
`endif
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase

        // Register fields the format actually uses; the rest stay `NULL.
        case (d.typ)
            T_I, T_L: begin d.rs1 = {1'b0, inst[19:15]}; d.rd = {1'b0, inst[11:7]}; end
            T_S, T_B: begin d.rs1 = {1'b0, inst[19:15]}; d.rs2 = {1'b0, inst[24:20]}; end
            T_U, T_J: d.rd = {1'b0, inst[11:7]};
            T_R: begin
                d.rs1 = {1'b0, inst[19:15]};
                d.rs2 = {1'b0, inst[24:20]};
                d.rd  = {1'b0, inst[11:7]};
            end
            default: d.rd = `NULL;
        endcase

        // Immediate per format; shift-immediates carry a zero-extended shamt.
        case (d.typ)
            T_I, T_L: begin
                if ((d.op == OP_SLLI) || (d.op == OP_SRLI) || (d.op == OP_SRAI)) begin
                    d.imm = {27'd0, inst[24:20]};
                end else begin
                    d.imm = {{20{inst[31]}}, inst[31:20]};
                end
            end
            T_S:     d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            T_B:     d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            T_U:     d.imm = {inst[31:12], 12'd0};
            T_J:     d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: d.imm = 32'd0;
        endcase

        // Writes to x0 are architecturally dead, so the destination is suppressed.
        if (d.rd == 6'd0) begin
            d.rd = `NULL;
        end else begin
            d.rd = d.rd;
        end

        // An illegal word must not leak partially decoded fields.
        if (bad) begin
            d.op  = OP_NOP;
            d.typ = T_NONE;
            d.rs1 = `NULL;
            d.rs2 = `NULL;
            d.rd  = `NULL;
            d.imm = 32'd0;
        end else begin
            d.op = d.op;
        end
        d.illegal = bad;
        return d;
    endfunction

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             valid_q, valid_d;
    logic [31:0]      pc_q, pc_d;
    dec_t             out_q, out_d;
    dec_t             head_dec_s;
    logic [63:0]      head_s;
    logic             full_s;
    logic             push_s;
    logic             load_s;

    assign full_s     = (count_q == FULL_CNT);
    assign head_s     = mem_q[rd_ptr_q];
    assign head_dec_s = decode(head_s[31:0]);
    // A pop never frees space for a same-cycle push: push looks only at the current count.
    assign push_s     = rdy_in & ~flush_in & fetch_valid & ~full_s;
    assign load_s     = rdy_in & ~flush_in & (count_q != '0) & (~valid_q | issue_ready);

    // FIFO storage write; contents need no reset because pointers define occupancy.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {fetch_pc, fetch_inst};
        end
    end

    // Next-state for pointers, occupancy and output register (flush wins over push/pop/load).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        out_d    = out_q;
        if (rdy_in && flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else if (rdy_in) begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (load_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                valid_d  = 1'b1;
                pc_d     = head_s[63:32];
                out_d    = head_dec_s;
            end else if (issue_ready) begin
                valid_d  = 1'b0;
            end else begin
                valid_d  = valid_q;
            end
            case ({push_s, load_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end else begin
            valid_d = valid_q;
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            pc_q          <= 32'd0;
            out_q.op      <= OP_NOP;
            out_q.typ     <= T_NONE;
            out_q.rs1     <= `NULL;
            out_q.rs2     <= `NULL;
            out_q.rd      <= `NULL;
            out_q.imm     <= 32'd0;
            out_q.illegal <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            out_q    <= out_d;
        end
    end

    assign fetch_ready   = ~full_s;
    assign count         = count_q;
    assign issue_valid   = valid_q;
    assign issue_pc      = pc_q;
    assign issue_op      = out_q.op;
    assign issue_type    = out_q.typ;
    assign issue_rs1     = out_q.rs1;
    assign issue_rs2     = out_q.rs2;
    assign issue_rd      = out_q.rd;
    assign issue_imm     = out_q.imm;
    assign issue_illegal = out_q.illegal;

endmodule

// File: tb/tb_inst_queue_decoder.sv
// Directed self-checking bench for inst_queue_decoder.
module tb_inst_queue_decoder;

    localparam logic [5:0] NUL     = 6'd32;
    localparam logic [5:0] O_LUI   = 6'd1;
    localparam logic [5:0] O_BEQ   = 6'd5;
    localparam logic [5:0] O_SW    = 6'd18;
    localparam logic [5:0] O_ADDI  = 6'd19;
    localparam logic [5:0] O_SRAI  = 6'd27;
    localparam logic [5:0] O_MUL   = 6'd38;
    localparam logic [2:0] TY_I = 3'd1, TY_S = 3'd3, TY_B = 3'd4, TY_U = 3'd5, TY_R = 3'd7;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, fvalid, iready;
    logic [31:0] finst, fpc;
    logic        fready, ivalid, iillegal;
    logic [31:0] ipc, iimm;
    logic [5:0]  iop, irs1, irs2, ird;
    logic [2:0]  itype;
    logic [3:0]  cnt;
    logic [59:0] dec_got;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign dec_got = {iop, itype, irs1, irs2, ird, iimm, iillegal};

    inst_queue_decoder #(.DEPTH(8), .PTR_W(3)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .fetch_valid(fvalid), .fetch_inst(finst), .fetch_pc(fpc), .fetch_ready(fready),
        .issue_ready(iready), .issue_valid(ivalid), .issue_pc(ipc), .issue_op(iop),
        .issue_type(itype), .issue_rs1(irs1), .issue_rs2(irs2), .issue_rd(ird),
        .issue_imm(iimm), .issue_illegal(iillegal), .count(cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; fvalid = 1'b0; iready = 1'b0;
        finst = 32'd0; fpc = 32'd0;
        #3;
        n_checks++;
        if ({ivalid, fready, cnt} !== {1'b0, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required %b", {ivalid, fready, cnt}, 6'b010000);
        end
        n_checks++;
        if ({dec_got, ipc} !== {6'd0, 3'd0, NUL, NUL, NUL, 32'd0, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL reset_fields: got %h/%h", dec_got, ipc);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_addi;
        iready = 1'b1;
        fvalid = 1'b1; finst = 32'h0050_0093; fpc = 32'h0000_1000;
        tick();
        fvalid = 1'b0;
        n_checks++;
        if ({ivalid, cnt} !== {1'b0, 4'd1}) begin
            n_fail++; $display("FAIL addi_push: got valid=%b count=%0d required 0/1", ivalid, cnt);
        end
        tick();
        n_checks++;
        if ({ivalid, ipc, dec_got} !== {1'b1, 32'h1000, O_ADDI, TY_I, 6'd0, NUL, 6'd1, 32'd5, 1'b0}) begin
            n_fail++; $display("FAIL addi_decode: got v=%b pc=%h dec=%h", ivalid, ipc, dec_got);
        end
        tick();
        n_checks++;
        if ({ivalid, cnt} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL addi_drain: got valid=%b count=%0d required 0/0", ivalid, cnt);
        end
    endtask

    task automatic test_beq;
        fvalid = 1'b1; finst = 32'hFE20_8EE3; fpc = 32'h0000_2000;
        tick();
        fvalid = 1'b0;
        tick();
        n_checks++;
        if ({ivalid, dec_got} !== {1'b1, O_BEQ, TY_B, 6'd1, 6'd2, NUL, 32'hFFFF_FFFC, 1'b0}) begin
            n_fail++; $display("FAIL beq_decode: got v=%b dec=%h", ivalid, dec_got);
        end
        tick();
    endtask

    task automatic test_rdy_freeze;
        rdy = 1'b0; fvalid = 1'b1; finst = 32'h0050_0093;
        tick(); tick();
        n_checks++;
        if ({ivalid, cnt} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL rdy_freeze: got valid=%b count=%0d required 0/0", ivalid, cnt);
        end
        fvalid = 1'b0; rdy = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        iready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fvalid = (i < 3);
            finst  = 32'h0000_0093 | (i << 20);
            fpc    = 32'h3000 + 32'(i * 4);
            tick();
            if (i > 0) begin
                n_checks++;
                if ({ivalid, ipc, iimm, cnt} !== {1'b1, 32'h3000 + 32'((i - 1) * 4), 32'(i - 1), (i < 3) ? 4'd1 : 4'd0}) begin
                    n_fail++; $display("FAIL b2b_%0d: got v=%b pc=%h imm=%h count=%0d", i, ivalid, ipc, iimm, cnt);
                end
            end
        end
        fvalid = 1'b0;
        tick();
    endtask

    task automatic test_full;
        iready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            fvalid = 1'b1; finst = 32'h0000_0093 | (i << 20); fpc = 32'h100 + 32'(i * 4);
            tick();
        end
        n_checks++;
        if ({ivalid, fready, cnt} !== {1'b1, 1'b0, 4'd8}) begin
            n_fail++; $display("FAIL full_state: got v=%b fr=%b count=%0d required 1/0/8", ivalid, fready, cnt);
        end
        fpc = 32'h200; finst = 32'h0630_0093;
        tick();
        fvalid = 1'b0;
        n_checks++;
        if ({cnt, ipc} !== {4'd8, 32'h100}) begin
            n_fail++; $display("FAIL full_tenth: got count=%0d pc=%h required 8/100", cnt, ipc);
        end
        iready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            tick();
            n_checks++;
            if ({ivalid, ipc, iimm} !== {1'b1, 32'h100 + 32'(i * 4), 32'(i)}) begin
                n_fail++; $display("FAIL drain_%0d: got v=%b pc=%h imm=%h", i, ivalid, ipc, iimm);
            end
        end
        tick();
        n_checks++;
        if ({ivalid, cnt, fready} !== {1'b0, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL drain_end: got v=%b count=%0d fr=%b", ivalid, cnt, fready);
        end
    endtask

    task automatic test_flush;
        iready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fvalid = 1'b1; finst = 32'h0000_0093; fpc = 32'h400 + 32'(i * 4);
            tick();
        end
        n_checks++;
        if ({ivalid, cnt} !== {1'b1, 4'd4}) begin
            n_fail++; $display("FAIL flush_pre: got v=%b count=%0d required 1/4", ivalid, cnt);
        end
        flush = 1'b1; fpc = 32'h500;
        tick();
        flush = 1'b0; fvalid = 1'b0;
        n_checks++;
        if ({ivalid, cnt} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL flush_post: got v=%b count=%0d required 0/0", ivalid, cnt);
        end
        iready = 1'b1;
        tick();
        n_checks++;
        if ({ivalid, cnt} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL flush_lost: got v=%b count=%0d required 0/0", ivalid, cnt);
        end
    endtask

    task automatic test_illegal_x0;
        iready = 1'b1;
        fvalid = 1'b1; finst = 32'hFFFF_FFFF; fpc = 32'h600;
        tick();
        finst = 32'h0000_0013; fpc = 32'h604;
        tick();
        fvalid = 1'b0;
        n_checks++;
        if ({ivalid, dec_got} !== {1'b1, 6'd0, 3'd0, NUL, NUL, NUL, 32'd0, 1'b1}) begin
            n_fail++; $display("FAIL illegal: got v=%b dec=%h", ivalid, dec_got);
        end
        tick();
        n_checks++;
        if ({ivalid, dec_got} !== {1'b1, O_ADDI, TY_I, 6'd0, NUL, NUL, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL nop_x0: got v=%b dec=%h", ivalid, dec_got);
        end
        tick();
    endtask

    task automatic test_formats;
        logic [31:0] words [3];
        logic [59:0] exp   [3];
        words[0] = 32'h0020_A423; exp[0] = {O_SW,   TY_S, 6'd1, 6'd2, NUL,  32'd8,         1'b0};
        words[1] = 32'h1234_52B7; exp[1] = {O_LUI,  TY_U, NUL,  NUL,  6'd5, 32'h1234_5000, 1'b0};
        words[2] = 32'h4072_5193; exp[2] = {O_SRAI, TY_I, 6'd4, NUL,  6'd3, 32'd7,         1'b0};
        iready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fvalid = 1'b1; finst = words[i];
            tick();
            fvalid = 1'b0;
            tick();
            n_checks++;
            if ({ivalid, dec_got} !== {1'b1, exp[i]}) begin
                n_fail++; $display("FAIL format_%0d: got v=%b dec=%h required %h", i, ivalid, dec_got, exp[i]);
            end
        end
        tick();
    endtask

    task automatic test_rv32m;
        logic [59:0] exp;
`ifdef DECODE_RV32M_EN
        exp = {O_MUL, TY_R, 6'd1, 6'd2, 6'd3, 32'd0, 1'b0};
`else
        exp = {6'd0, 3'd0, NUL, NUL, NUL, 32'd0, 1'b1};
`endif
        fvalid = 1'b1; finst = 32'h0220_81B3;
        tick();
        fvalid = 1'b0;
        tick();
        n_checks++;
        if ({ivalid, dec_got} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL rv32m: got v=%b dec=%h required %h", ivalid, dec_got, exp);
        end
        tick();
    endtask

    task automatic test_async_reset;
        iready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fvalid = 1'b1; finst = 32'h0000_0093;
            tick();
        end
        fvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ivalid, cnt, fready} !== {1'b0, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL async_reset: got v=%b count=%0d fr=%b", ivalid, cnt, fready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_beq();
        test_rdy_freeze();
        test_back_to_back();
        test_full();
        test_flush();
        test_illegal_x0();
        test_formats();
        test_rv32m();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
